// File: rtl/sprite_compositor.sv
// Per-pixel sprite layer compositor: picks the top layer by fixed priority,
// drives the sprite ROM, produces the palette index two cycles later and
// gathers per-frame bullet/enemy and enemy/player overlap flags.
module sprite_compositor #(
  parameter int N_ENEMY      = 4,
  parameter int ADDR_W       = 13,
  parameter int COLOR_W      = 4,
  parameter int TRANSPARENT  = 0,
  parameter int BG_COLOR     = 1,
  parameter int BULLET_COLOR = 15
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        pixel_valid,
  input  logic                        frame_start,
  input  logic [8:0]                  PixelX,
  input  logic [8:0]                  PixelY,
  input  logic [N_ENEMY-1:0]          enemy_is_obj,
  input  logic [N_ENEMY*ADDR_W-1:0]   enemy_address,
  input  logic                        player_is_obj,
  input  logic [ADDR_W-1:0]           player_address,
  input  logic                        bullet_is_obj,
  output logic [ADDR_W:0]             rom_addr,
  input  logic [COLOR_W-1:0]          rom_data,
  output logic [COLOR_W-1:0]          color_out,
  output logic                        color_valid,
  output logic [8:0]                  out_x,
  output logic [8:0]                  out_y,
  output logic [N_ENEMY-1:0]          hit_vec,
  output logic                        player_contact,
  output logic                        hit_strobe
);

  typedef enum logic [1:0] {TAG_BG, TAG_ENEMY, TAG_PLAYER, TAG_BULLET} tag_e;

  localparam logic [COLOR_W-1:0] BG_C     = COLOR_W'(BG_COLOR);
  localparam logic [COLOR_W-1:0] BULLET_C = COLOR_W'(BULLET_COLOR);
  localparam logic [COLOR_W-1:0] TRANS_C  = COLOR_W'(TRANSPARENT);

  // Sprite layers show their ROM colour; a transparent texel falls to the
  // background colour, never to a lower sprite.
  function automatic logic [COLOR_W-1:0] resolve_color(tag_e tag, logic [COLOR_W-1:0] rd);
    case (tag)
      TAG_BULLET: return BULLET_C;
      TAG_BG:     return BG_C;
      default:    return (rd == TRANS_C) ? BG_C : rd;
    endcase
  endfunction

  tag_e               tag_d, tag_p1_q, tag_p2_q;
  logic [ADDR_W:0]    rom_addr_d, rom_addr_q;
  logic [ADDR_W-1:0]  enemy_sel_addr;
  logic               vld_p1_q, vld_p2_q;
  logic [8:0]         x_p1_q, y_p1_q, x_p2_q, y_p2_q;

  logic [N_ENEMY-1:0] hit_terms, hit_acc_d, hit_acc_q, hit_vec_q;
  logic               contact_term, contact_acc_d, contact_acc_q;
  logic               player_contact_q, hit_strobe_q;

  // Layer selection: winner tag and the ROM address it needs (held otherwise).
  always_comb begin
    tag_d          = TAG_BG;
    rom_addr_d     = rom_addr_q;
    enemy_sel_addr = '0;
    for (int i = N_ENEMY - 1; i >= 0; i--) begin
      if (enemy_is_obj[i]) enemy_sel_addr = enemy_address[i*ADDR_W +: ADDR_W];
    end
    if (bullet_is_obj) begin
      tag_d = TAG_BULLET;
    end else if (player_is_obj) begin
      tag_d      = TAG_PLAYER;
      rom_addr_d = {1'b1, player_address};
    end else if (|enemy_is_obj) begin
      tag_d      = TAG_ENEMY;
      rom_addr_d = {1'b0, enemy_sel_addr};
    end
  end

  // Stage 1: register winner, ROM address and coordinates.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tag_p1_q   <= TAG_BG;
      rom_addr_q <= '0;
      vld_p1_q   <= 1'b0;
      x_p1_q     <= '0;
      y_p1_q     <= '0;
    end else begin
      tag_p1_q   <= tag_d;
      rom_addr_q <= rom_addr_d;
      vld_p1_q   <= pixel_valid;
      x_p1_q     <= PixelX;
      y_p1_q     <= PixelY;
    end
  end

  // Stage 2: align tag and coordinates with the ROM data returning this cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tag_p2_q <= TAG_BG;
      vld_p2_q <= 1'b0;
      x_p2_q   <= '0;
      y_p2_q   <= '0;
    end else begin
      tag_p2_q <= tag_p1_q;
      vld_p2_q <= vld_p1_q;
      x_p2_q   <= x_p1_q;
      y_p2_q   <= y_p1_q;
    end
  end

  // Overlap terms count only on visible pixels; frame_start reloads rather than clears.
  always_comb begin
    hit_terms     = pixel_valid ? (enemy_is_obj & {N_ENEMY{bullet_is_obj}}) : '0;
    contact_term  = pixel_valid & player_is_obj & (|enemy_is_obj);
    hit_acc_d     = frame_start ? hit_terms : (hit_acc_q | hit_terms);
    contact_acc_d = frame_start ? contact_term : (contact_acc_q | contact_term);
  end

  // Per-frame accumulation and report registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_acc_q        <= '0;
      contact_acc_q    <= 1'b0;
      hit_vec_q        <= '0;
      player_contact_q <= 1'b0;
      hit_strobe_q     <= 1'b0;
    end else begin
      hit_acc_q     <= hit_acc_d;
      contact_acc_q <= contact_acc_d;
      hit_strobe_q  <= frame_start;
      if (frame_start) begin
        hit_vec_q        <= hit_acc_q;
        player_contact_q <= contact_acc_q;
      end
    end
  end

  assign rom_addr       = rom_addr_q;
  assign color_out      = resolve_color(tag_p2_q, rom_data);
  assign color_valid    = vld_p2_q;
  assign out_x          = x_p2_q;
  assign out_y          = y_p2_q;
  assign hit_vec        = hit_vec_q;
  assign player_contact = player_contact_q;
  assign hit_strobe     = hit_strobe_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed pixel sequences, a frame-level
// reference model checked every cycle, and hand-computed spot checks.
module tb_sprite_compositor;

  localparam int NE = 4;
  localparam int AW = 13;
  localparam int CW = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              pixel_valid = 1'b0;
  logic              frame_start = 1'b0;
  logic [8:0]        PixelX = '0, PixelY = '0;
  logic [NE-1:0]     enemy_is_obj = '0;
  logic [NE*AW-1:0]  enemy_address;
  logic              player_is_obj = 1'b0;
  logic [AW-1:0]     player_address = '0;
  logic              bullet_is_obj = 1'b0;
  logic [AW:0]       rom_addr;
  logic [CW-1:0]     rom_data = '0;
  logic [CW-1:0]     color_out;
  logic              color_valid;
  logic [8:0]        out_x, out_y;
  logic [NE-1:0]     hit_vec;
  logic              player_contact, hit_strobe;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign enemy_address = {13'h04A, 13'h037, 13'h025, 13'h010};

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .PixelX(PixelX), .PixelY(PixelY), .enemy_is_obj(enemy_is_obj),
    .enemy_address(enemy_address), .player_is_obj(player_is_obj),
    .player_address(player_address), .bullet_is_obj(bullet_is_obj),
    .rom_addr(rom_addr), .rom_data(rom_data), .color_out(color_out),
    .color_valid(color_valid), .out_x(out_x), .out_y(out_y), .hit_vec(hit_vec),
    .player_contact(player_contact), .hit_strobe(hit_strobe)
  );

  always #10 Clk = ~Clk;

  // Sprite ROM contents: enemy sheet = low nibble, player sheet = low nibble + 3.
  function automatic logic [CW-1:0] rom_fn(logic [AW:0] a);
    return a[AW] ? (a[3:0] + 4'd3) : a[3:0];
  endfunction

  // Synchronous ROM: one-cycle read latency.
  always_ff @(posedge Clk) rom_data <= rom_fn(rom_addr);

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       v;
    logic [8:0] x;
    logic [8:0] y;
    logic [3:0] c;
  } exp_t;

  localparam exp_t IDLE_EXP = '{v: 1'b0, x: 9'd0, y: 9'd0, c: 4'd1};

  exp_t          m_cur = IDLE_EXP, m_prev = IDLE_EXP;
  logic [AW:0]   m_rom = '0;
  logic [NE-1:0] m_acc = '0, m_hv = '0;
  logic          m_cacc = 1'b0, m_pc = 1'b0, m_hs = 1'b0;
  logic          live = 1'b0;

  function automatic int lowest_enemy();
    for (int i = 0; i < NE; i++) if (enemy_is_obj[i]) return i;
    return -1;
  endfunction

  function automatic logic [AW:0] enemy_rom(int i);
    logic [NE*AW-1:0] all;
    all = enemy_address;
    return {1'b0, all[i*AW +: AW]};
  endfunction

  function automatic logic [3:0] sprite_color(logic [AW:0] a);
    logic [3:0] c;
    c = rom_fn(a);
    return (c == 4'd0) ? 4'd1 : c;
  endfunction

  function automatic exp_t model_pixel();
    exp_t e;
    int   k;
    e.v = pixel_valid; e.x = PixelX; e.y = PixelY;
    k = lowest_enemy();
    if (bullet_is_obj)      e.c = 4'd15;
    else if (player_is_obj) e.c = sprite_color({1'b1, player_address});
    else if (k >= 0)        e.c = sprite_color(enemy_rom(k));
    else                    e.c = 4'd1;
    return e;
  endfunction

  function automatic logic [AW:0] model_rom(logic [AW:0] held);
    int k;
    k = lowest_enemy();
    if (bullet_is_obj)      return held;
    else if (player_is_obj) return {1'b1, player_address};
    else if (k >= 0)        return enemy_rom(k);
    return held;
  endfunction

  function automatic logic [NE-1:0] model_hits();
    return (pixel_valid && bullet_is_obj) ? enemy_is_obj : '0;
  endfunction

  function automatic logic model_contact();
    return pixel_valid && player_is_obj && (enemy_is_obj != '0);
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      live   <= 1'b1;
      m_cur  <= IDLE_EXP;
      m_prev <= IDLE_EXP;
      m_rom  <= '0;
      m_acc  <= '0;
      m_cacc <= 1'b0;
      m_hv   <= '0;
      m_pc   <= 1'b0;
      m_hs   <= 1'b0;
    end else begin
      m_prev <= m_cur;
      m_cur  <= model_pixel();
      m_rom  <= model_rom(m_rom);
      m_hs   <= frame_start;
      if (frame_start) begin
        m_hv   <= m_acc;
        m_pc   <= m_cacc;
        m_acc  <= model_hits();
        m_cacc <= model_contact();
      end else begin
        m_acc  <= m_acc | model_hits();
        m_cacc <= m_cacc | model_contact();
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge Clk) begin
    if (live) begin
      check("m_color_valid", 32'(color_valid), 32'(m_prev.v));
      if (m_prev.v) begin
        check("m_color_out", 32'(color_out), 32'(m_prev.c));
        check("m_out_x", 32'(out_x), 32'(m_prev.x));
        check("m_out_y", 32'(out_y), 32'(m_prev.y));
      end
      check("m_rom_addr", 32'(rom_addr), 32'(m_rom));
      check("m_hit_vec", 32'(hit_vec), 32'(m_hv));
      check("m_player_contact", 32'(player_contact), 32'(m_pc));
      check("m_hit_strobe", 32'(hit_strobe), 32'(m_hs));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_in();
    pixel_valid = 1'b0; frame_start = 1'b0; PixelX = '0; PixelY = '0;
    enemy_is_obj = '0; player_is_obj = 1'b0; player_address = '0; bullet_is_obj = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    check({tag, "_color_out"}, 32'(color_out), 32'd1);
    check({tag, "_color_valid"}, 32'(color_valid), 32'd0);
    check({tag, "_out_x"}, 32'(out_x), 32'd0);
    check({tag, "_out_y"}, 32'(out_y), 32'd0);
    check({tag, "_hit_vec"}, 32'(hit_vec), 32'd0);
    check({tag, "_contact"}, 32'(player_contact), 32'd0);
    check({tag, "_strobe"}, 32'(hit_strobe), 32'd0);
  endtask

  initial begin
    clear_in();
    Reset = 1'b1;
    tick(); tick();
    @(negedge Clk);
    check_reset_values("reset");
    tick();
    Reset = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;

    // Pipeline alignment: player at (50,60), address 100.
    pixel_valid = 1'b1; PixelX = 9'd50; PixelY = 9'd60;
    player_is_obj = 1'b1; player_address = 13'd100;
    tick(); clear_in();
    @(negedge Clk);
    check("align_rom_addr", 32'(rom_addr), 32'h2064);
    tick();
    @(negedge Clk);
    check("align_color", 32'(color_out), 32'd7);
    check("align_x", 32'(out_x), 32'd50);
    check("align_y", 32'(out_y), 32'd60);
    check("align_valid", 32'(color_valid), 32'd1);

    // Priority: everything set, then only enemies 1 and 2.
    pixel_valid = 1'b1; PixelX = 9'd1; PixelY = 9'd2;
    bullet_is_obj = 1'b1; player_is_obj = 1'b1; player_address = 13'd200;
    enemy_is_obj = 4'b0110;
    tick();
    bullet_is_obj = 1'b0; player_is_obj = 1'b0; PixelX = 9'd3;
    tick(); clear_in();
    @(negedge Clk);
    check("prio_bullet_color", 32'(color_out), 32'd15);
    check("prio_enemy_rom", 32'(rom_addr), 32'h0025);
    tick();
    @(negedge Clk);
    check("prio_enemy_color", 32'(color_out), 32'd5);

    // Transparency: enemy 0 texel is transparent, enemy 2 below must not show.
    pixel_valid = 1'b1; PixelX = 9'd4; enemy_is_obj = 4'b0101;
    tick(); clear_in();
    tick();
    @(negedge Clk);
    check("transp_color", 32'(color_out), 32'd1);
    check("transp_valid", 32'(color_valid), 32'd1);

    // Flush the frame, then bubbles with bullet+enemy only on invalid cycles.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pixel_valid   = (i % 2 == 0);
      PixelX        = 9'(i + 10);
      bullet_is_obj = !pixel_valid;
      enemy_is_obj  = pixel_valid ? 4'b0000 : 4'b0010;
      tick();
      @(negedge Clk);
      if (i > 0) check("bubble_valid", 32'(color_valid), 32'((i - 1) % 2 == 0));
    end
    clear_in();
    tick();
    @(negedge Clk);
    check("bubble_tail_valid", 32'(color_valid), 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    @(negedge Clk);
    check("bubble_hit_vec", 32'(hit_vec), 32'd0);
    check("bubble_contact", 32'(player_contact), 32'd0);

    // Frame hit reporting.
    pixel_valid = 1'b1; bullet_is_obj = 1'b1; enemy_is_obj = 4'b0100;
    tick(); clear_in();
    pixel_valid = 1'b1; player_is_obj = 1'b1; enemy_is_obj = 4'b0001;
    tick(); clear_in();
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    @(negedge Clk);
    check("frame_hit_vec", 32'(hit_vec), 32'h4);
    check("frame_contact", 32'(player_contact), 32'd1);
    check("frame_strobe_hi", 32'(hit_strobe), 32'd1);
    tick();
    @(negedge Clk);
    check("frame_strobe_lo", 32'(hit_strobe), 32'd0);
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    @(negedge Clk);
    check("empty_hit_vec", 32'(hit_vec), 32'd0);
    check("empty_contact", 32'(player_contact), 32'd0);

    // Hit on the frame_start cycle belongs to the new frame.
    frame_start = 1'b1; pixel_valid = 1'b1; bullet_is_obj = 1'b1; enemy_is_obj = 4'b1000;
    tick(); clear_in();
    @(negedge Clk);
    check("boundary_now", 32'(hit_vec), 32'd0);
    tick(); tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    @(negedge Clk);
    check("boundary_next", 32'(hit_vec), 32'h8);

    // Reset mid-frame with hits accumulated and pixels in flight.
    pixel_valid = 1'b1; PixelX = 9'd77; bullet_is_obj = 1'b1; enemy_is_obj = 4'b0010;
    tick();
    bullet_is_obj = 1'b0; player_is_obj = 1'b1; player_address = 13'd5; enemy_is_obj = 4'b0001;
    Reset = 1'b1;
    tick(); clear_in();
    @(negedge Clk);
    check_reset_values("midreset");
    Reset = 1'b0;
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    @(negedge Clk);
    check("post_reset_hit_vec", 32'(hit_vec), 32'd0);
    check("post_reset_contact", 32'(player_contact), 32'd0);
    check("post_reset_strobe", 32'(hit_strobe), 32'd1);
    tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
